axi_vga_fetch_sched: RTL and testbench
======================================

# axi_vga_fetch_sched

Pixel-clock-domain scheduler that sequences framebuffer reads for the VGA output path. Per frame it walks the visible area line by line and issues burst read requests (address, pixel count) to the read DMA. Issue is gated by free space in the downstream pixel FIFO, tracked as reserved-slot credits. It also flags FIFO underflow during visible pixels and frames that restart before the fetch completes.

## Interface
Parameters:
- AddrWidth, 64, framebuffer address width
- BurstLen, 16, max pixels per request (≥1, ≤255)
- FifoDepth, 64, pixel FIFO depth in pixels (≥ BurstLen)
- PixelBytes, 2, bytes per pixel

Ports:
- pxl_clk  in  1  pixel clock
- rst_ni  in  1  reset: asynchronous, active-low
- enable_i  in  1  scheduler enable (control.enable)
- fb_base_i  in  AddrWidth  framebuffer base address, sampled at frame start
- stride_i  in  32  line pitch in bytes, sampled at frame start
- h_visible_i  in  16  pixels per line (≥1), sampled at frame start
- v_visible_i  in  16  lines per frame (≥1), sampled at frame start
- frame_start_i  in  1  one-cycle pulse, vertical back porch → visible transition
- visible_i  in  1  timing-FSM visible flag
- fifo_nonempty_i  in  1  pixel FIFO holds ≥1 pixel
- pop_i  in  1  one pixel consumed from FIFO this cycle
- req_valid_o  out  1  burst request valid
- req_ready_i  in  1  DMA accepts request
- req_addr_o  out  AddrWidth  burst start byte address
- req_len_o  out  8  burst length in pixels (1..BurstLen)
- busy_o  out  1  frame fetch in progress
- underflow_o  out  1  sticky: visible_i & !fifo_nonempty_i seen
- overrun_o  out  1  sticky: frame_start_i while fetch incomplete

## Operation
- States: IDLE, WAIT_FRAME, CREDIT, ISSUE.
- IDLE: enable_i=1 → WAIT_FRAME.
- WAIT_FRAME: frame_start_i → latch inputs; line_addr=fb_base_i, pix_off=0, line_cnt=0; → CREDIT.
- CREDIT: len = min(BurstLen, h_visible − pix_off); if FifoDepth − reserved ≥ len → load req_addr_o = line_addr + pix_off·PixelBytes, req_len_o = len → ISSUE.
- ISSUE: req_valid_o=1. Address and length held stable until req_valid_o & req_ready_i.
  - On handshake: reserved += len; pix_off += len.
  - If pix_off reaches h_visible: pix_off=0, line_addr += stride, line_cnt++.
  - If line_cnt reaches v_visible → WAIT_FRAME, else → CREDIT.
- reserved counter, width clog2(FifoDepth+1):
  - +len on handshake, −1 on pop_i; both in one cycle apply net.
  - pop_i at reserved=0 is ignored (saturate, no wrap).
- Address arithmetic modulo 2^AddrWidth; stride zero-extended.
- busy_o=1 in CREDIT and ISSUE.
- frame_start_i in CREDIT/ISSUE:
  - Set overrun_o.
  - In CREDIT: restart the frame (re-latch, → CREDIT).
  - In ISSUE: finish the pending handshake first, then restart.
- enable_i=0:
  - From WAIT_FRAME/CREDIT → IDLE immediately.
  - From ISSUE → IDLE after the pending handshake completes. A valid request is never withdrawn.
  - reserved keeps tracking pops.
- underflow_o, overrun_o: cleared only by reset.

## Timing
- Reset values: req_valid_o=0, req_addr_o=0, req_len_o=0, busy_o=0, underflow_o=0, overrun_o=0, reserved=0, state IDLE.
- All outputs registered.
- frame_start_i at cycle N (credit available) → CREDIT at N+1, req_valid_o=1 at N+2.
- After a handshake at cycle N, req_valid_o=0 at N+1. The next request asserts no earlier than N+2, and exactly N+2 if credit suffices. Throughput: one request per 2 cycles max.
- Credit check uses registered reserved. A pop in the CREDIT cycle counts the following cycle.
- underflow_o sets the cycle after the offending sample.
- overrun_o sets the cycle after the offending frame_start_i.

## Test plan
- Burst split: base=0x8000_0000, h_visible=40, v_visible=2, stride=128, BurstLen=16, req_ready_i=1, pops keep FIFO drained.
  → requests (0x80000000,16), (0x80000020,16), (0x80000040,8), (0x80000080,16), (0x800000A0,16), (0x800000C0,8); then WAIT_FRAME with busy_o=0.
- Credit stall: FifoDepth=64, no pops, h_visible=200.
  → exactly 4 requests of 16, then req_valid_o stays 0. One pop is insufficient (need 16). After 16 pops, the 5th request asserts within 2 cycles.
- Backpressure: req_ready_i=0 for 10 cycles, with enable_i dropped mid-wait.
  → addr/len stable, req_valid_o held for all 10 cycles. After the handshake, IDLE; no further requests.
- Overrun: second frame_start_i after 3 of 6 bursts.
  → overrun_o=1 next cycle; next request addr=fb_base_i, len=16.
- Underflow: visible_i=1, fifo_nonempty_i=0 for one cycle.
  → underflow_o=1 the next cycle and stays set until rst_ni.
- Async reset mid-ISSUE.
  → req_valid_o=0 immediately; all outputs at reset values; after release, no request until enable_i and frame_start_i.

Source files
------------

// File: rtl/axi_vga_fetch_sched.sv
// Pixel-clock fetch scheduler: walks the visible frame and issues credit-gated
// burst read requests to the read DMA, flagging FIFO underflow and frame overrun.
module axi_vga_fetch_sched #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned BurstLen   = 16,
    parameter int unsigned FifoDepth  = 64,
    parameter int unsigned PixelBytes = 2
) (
    input  logic                 pxl_clk,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [AddrWidth-1:0] fb_base_i,
    input  logic [31:0]          stride_i,
    input  logic [15:0]          h_visible_i,
    input  logic [15:0]          v_visible_i,
    input  logic                 frame_start_i,
    input  logic                 visible_i,
    input  logic                 fifo_nonempty_i,
    input  logic                 pop_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [7:0]           req_len_o,
    output logic                 busy_o,
    output logic                 underflow_o,
    output logic                 overrun_o
);

    localparam int unsigned ResW = $clog2(FifoDepth + 1);
    localparam logic [AddrWidth-1:0] PixB = AddrWidth'(PixelBytes);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CREDIT, ISSUE} state_e;
    state_e state_q, state_d;

    logic [AddrWidth-1:0] line_addr_q, req_addr_q;
    logic [31:0]          stride_q;
    logic [15:0]          h_vis_q, v_vis_q, pix_off_q, line_cnt_q;
    logic [ResW-1:0]      reserved_q;
    logic [7:0]           req_len_q;
    logic                 restart_pend_q, req_valid_q, busy_q, underflow_q, overrun_q;

    logic [15:0] remain, pix_next;
    logic [7:0]  len_c;
    logic        credit_ok, hs, line_end, frame_end, latch, load, pop_eff;
    logic [ResW:0] res_sum;

    assign remain    = h_vis_q - pix_off_q;
    assign len_c     = (remain >= 16'(BurstLen)) ? 8'(BurstLen) : remain[7:0];
    assign credit_ok = (32'(reserved_q) + 32'(len_c)) <= 32'(FifoDepth);
    assign hs        = (state_q == ISSUE) && req_ready_i;
    assign pix_next  = pix_off_q + 16'(req_len_q);
    assign line_end  = (pix_next == h_vis_q);
    assign frame_end = line_end && ((line_cnt_q + 16'd1) == v_vis_q);
    assign pop_eff   = pop_i && (reserved_q != '0);
    assign res_sum   = {1'b0, reserved_q} + (hs ? (ResW+1)'(req_len_q) : '0);

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: if (enable_i) state_d = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable_i) state_d = IDLE;
                else if (frame_start_i) begin
                    latch   = 1'b1;
                    state_d = CREDIT;
                end
            end
            CREDIT: begin
                if (!enable_i) state_d = IDLE;
                else if (frame_start_i) latch = 1'b1;
                else if (credit_ok) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A pending request is never withdrawn; disable/restart wait for the handshake.
                if (hs) begin
                    if (!enable_i) state_d = IDLE;
                    else if (restart_pend_q || frame_start_i) begin
                        latch   = 1'b1;
                        state_d = CREDIT;
                    end else if (frame_end) state_d = WAIT_FRAME;
                    else state_d = CREDIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pxl_clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge pxl_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            line_addr_q    <= '0;
            stride_q       <= '0;
            h_vis_q        <= '0;
            v_vis_q        <= '0;
            pix_off_q      <= '0;
            line_cnt_q     <= '0;
            reserved_q     <= '0;
            req_addr_q     <= '0;
            req_len_q      <= '0;
            restart_pend_q <= 1'b0;
            req_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            underflow_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (latch) begin
                line_addr_q <= fb_base_i;
                stride_q    <= stride_i;
                h_vis_q     <= h_visible_i;
                v_vis_q     <= v_visible_i;
                pix_off_q   <= '0;
                line_cnt_q  <= '0;
            end else if (hs) begin
                if (line_end) begin
                    pix_off_q   <= '0;
                    line_addr_q <= line_addr_q + AddrWidth'(stride_q);
                    line_cnt_q  <= line_cnt_q + 16'd1;
                end else begin
                    pix_off_q <= pix_next;
                end
            end
            if (load) begin
                req_addr_q <= line_addr_q + AddrWidth'(pix_off_q) * PixB;
                req_len_q  <= len_c;
            end
            reserved_q     <= ResW'(res_sum - (ResW+1)'(pop_eff));
            restart_pend_q <= (state_q == ISSUE) && !hs && (restart_pend_q || frame_start_i);
            req_valid_q    <= (state_d == ISSUE);
            busy_q         <= (state_d == CREDIT) || (state_d == ISSUE);
            underflow_q    <= underflow_q | (visible_i & ~fifo_nonempty_i);
            overrun_q      <= overrun_q | (frame_start_i & ((state_q == CREDIT) || (state_q == ISSUE)));
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_len_o   = req_len_q;
    assign busy_o      = busy_q;
    assign underflow_o = underflow_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_axi_vga_fetch_sched.sv
// Self-checking bench for axi_vga_fetch_sched: frame vectors with a request
// scoreboard, plus credit stall, backpressure, overrun, underflow and reset sequences.
module tb_axi_vga_fetch_sched;

    logic        pxl_clk = 1'b0;
    logic        rst_ni;
    logic        enable_i, frame_start_i, visible_i, fifo_nonempty_i, pop_i, req_ready_i;
    logic [63:0] fb_base_i;
    logic [31:0] stride_i;
    logic [15:0] h_visible_i, v_visible_i;
    logic        req_valid_o, busy_o, underflow_o, overrun_o;
    logic [63:0] req_addr_o;
    logic [7:0]  req_len_o;

    axi_vga_fetch_sched #(
        .AddrWidth (64),
        .BurstLen  (16),
        .FifoDepth (64),
        .PixelBytes(2)
    ) dut (
        .pxl_clk        (pxl_clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .fb_base_i      (fb_base_i),
        .stride_i       (stride_i),
        .h_visible_i    (h_visible_i),
        .v_visible_i    (v_visible_i),
        .frame_start_i  (frame_start_i),
        .visible_i      (visible_i),
        .fifo_nonempty_i(fifo_nonempty_i),
        .pop_i          (pop_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_addr_o     (req_addr_o),
        .req_len_o      (req_len_o),
        .busy_o         (busy_o),
        .underflow_o    (underflow_o),
        .overrun_o      (overrun_o)
    );

    always #5 pxl_clk = ~pxl_clk;

    typedef struct {
        logic [63:0] base;
        logic [31:0] stride;
        logic [15:0] h;
        logic [15:0] v;
        int unsigned nreq;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t        exp_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned hs_cnt = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge pxl_clk);
        #1;
    endtask

    // Reference walk of the frame: line-major, bursts of at most 16 pixels.
    task automatic push_frame(input logic [63:0] base, input logic [31:0] stride,
                              input logic [15:0] h, input logic [15:0] v);
        for (int unsigned l = 0; l < v; l++) begin
            int unsigned off = 0;
            while (off < h) begin
                req_t r;
                int unsigned len = (h - off > 16) ? 16 : h - off;
                r.addr = base + 64'(l) * 64'(stride) + 64'(off) * 64'd2;
                r.len  = 8'(len);
                exp_q.push_back(r);
                off += len;
            end
        end
    endtask

    task automatic start_frame(input logic [63:0] base, input logic [31:0] stride,
                               input logic [15:0] h, input logic [15:0] v);
        fb_base_i     = base;
        stride_i      = stride;
        h_visible_i   = h;
        v_visible_i   = v;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < bound) begin
            tick();
            t++;
        end
        check("frame_done", 64'((exp_q.size() == 0) && !busy_o), 64'd1);
    endtask

    always @(negedge pxl_clk) begin : monitor
        req_t e;
        if (rst_ni && req_valid_o && req_ready_i) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected none", req_addr_o, req_len_o);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", req_addr_o, e.addr);
                check("req_len", 64'(req_len_o), 64'(e.len));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        int unsigned h0, t;
        logic [63:0] a0;
        logic [7:0]  l0;
        logic        ok;

        vecs[0] = '{64'h0000_0000_8000_0000, 32'd128, 16'd40, 16'd2, 6};
        vecs[1] = '{64'h0000_0000_0000_1000, 32'd64,  16'd16, 16'd3, 3};
        vecs[2] = '{64'h0000_0000_0000_2000, 32'd10,  16'd5,  16'd1, 1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 32'd256, 16'd33, 16'd2, 6};

        rst_ni = 1'b0; enable_i = 1'b0; frame_start_i = 1'b0; visible_i = 1'b0;
        fifo_nonempty_i = 1'b1; pop_i = 1'b1; req_ready_i = 1'b1;
        fb_base_i = '0; stride_i = '0; h_visible_i = '0; v_visible_i = '0;
        repeat (3) tick();
        check("rst_valid", 64'(req_valid_o), 64'd0);
        check("rst_addr", req_addr_o, 64'd0);
        check("rst_len", 64'(req_len_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_underflow", 64'(underflow_o), 64'd0);
        check("rst_overrun", 64'(overrun_o), 64'd0);
        rst_ni = 1'b1;
        enable_i = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            h0 = hs_cnt;
            push_frame(vecs[i].base, vecs[i].stride, vecs[i].h, vecs[i].v);
            start_frame(vecs[i].base, vecs[i].stride, vecs[i].h, vecs[i].v);
            check("fs_busy_n1", 64'(busy_o), 64'd1);
            check("fs_valid_n1", 64'(req_valid_o), 64'd0);
            tick();
            check("fs_valid_n2", 64'(req_valid_o), 64'd1);
            wait_done(2000);
            check("vec_nreq", 64'(hs_cnt - h0), 64'(vecs[i].nreq));
            check("vec_idle_valid", 64'(req_valid_o), 64'd0);
            repeat (80) tick();
        end

        // Credit stall: no pops, 64-pixel FIFO admits exactly four 16-pixel bursts.
        pop_i = 1'b0;
        h0 = hs_cnt;
        push_frame(64'd0, 32'd0, 16'd200, 16'd1);
        start_frame(64'd0, 32'd0, 16'd200, 16'd1);
        repeat (30) tick();
        check("stall_nreq", 64'(hs_cnt - h0), 64'd4);
        check("stall_valid", 64'(req_valid_o), 64'd0);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        repeat (5) tick();
        check("one_pop_nreq", 64'(hs_cnt - h0), 64'd4);
        check("one_pop_valid", 64'(req_valid_o), 64'd0);
        pop_i = 1'b1;
        repeat (15) tick();
        pop_i = 1'b0;
        t = 0;
        while (!req_valid_o && t < 2) begin
            tick();
            t++;
        end
        check("resume_valid", 64'(req_valid_o), 64'd1);
        pop_i = 1'b1;
        wait_done(3000);
        check("stall_total", 64'(hs_cnt - h0), 64'd13);
        repeat (80) tick();

        // Backpressure with enable dropped while the request is pending.
        req_ready_i = 1'b0;
        h0 = hs_cnt;
        exp_q.push_back('{64'h4000, 8'd16});
        start_frame(64'h4000, 32'd0, 16'd40, 16'd2);
        t = 0;
        while (!req_valid_o && t < 5) begin
            tick();
            t++;
        end
        a0 = req_addr_o;
        l0 = req_len_o;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) enable_i = 1'b0;
            if (!req_valid_o || req_addr_o != a0 || req_len_o != l0) ok = 1'b0;
            tick();
        end
        check("bp_hold", 64'(ok), 64'd1);
        req_ready_i = 1'b1;
        tick();
        check("bp_valid_after", 64'(req_valid_o), 64'd0);
        check("bp_busy_after", 64'(busy_o), 64'd0);
        repeat (20) tick();
        check("bp_nreq", 64'(hs_cnt - h0), 64'd1);
        check("bp_queue", 64'(exp_q.size()), 64'd0);
        enable_i = 1'b1;
        repeat (80) tick();

        // Overrun: restart after three of six bursts.
        check("ovr_pre", 64'(overrun_o), 64'd0);
        h0 = hs_cnt;
        push_frame(64'h9000, 32'd256, 16'd40, 16'd1);
        start_frame(64'h9000, 32'd256, 16'd40, 16'd2);
        t = 0;
        while (hs_cnt - h0 < 3 && t < 200) begin
            tick();
            t++;
        end
        check("ovr_mid_valid", 64'(req_valid_o), 64'd0);
        push_frame(64'h9000, 32'd256, 16'd40, 16'd2);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        check("overrun_set", 64'(overrun_o), 64'd1);
        wait_done(2000);
        check("ovr_nreq", 64'(hs_cnt - h0), 64'd9);
        repeat (5) tick();
        check("overrun_sticky", 64'(overrun_o), 64'd1);

        // Underflow: a single offending visible cycle.
        check("unf_pre", 64'(underflow_o), 64'd0);
        visible_i = 1'b1;
        fifo_nonempty_i = 1'b0;
        tick();
        visible_i = 1'b0;
        fifo_nonempty_i = 1'b1;
        check("underflow_set", 64'(underflow_o), 64'd1);
        repeat (5) tick();
        check("underflow_sticky", 64'(underflow_o), 64'd1);
        repeat (80) tick();

        // Asynchronous reset while a request is pending.
        req_ready_i = 1'b0;
        start_frame(64'h5000, 32'd0, 16'd40, 16'd1);
        t = 0;
        while (!req_valid_o && t < 5) begin
            tick();
            t++;
        end
        check("pre_rst_valid", 64'(req_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(req_valid_o), 64'd0);
        check("arst_addr", req_addr_o, 64'd0);
        check("arst_len", 64'(req_len_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_underflow", 64'(underflow_o), 64'd0);
        check("arst_overrun", 64'(overrun_o), 64'd0);
        h0 = hs_cnt;
        enable_i = 1'b0;
        req_ready_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (10) tick();
        enable_i = 1'b1;
        repeat (10) tick();
        check("post_rst_valid", 64'(req_valid_o), 64'd0);
        check("post_rst_nreq", 64'(hs_cnt - h0), 64'd0);
        push_frame(64'h6000, 32'd0, 16'd16, 16'd1);
        start_frame(64'h6000, 32'd0, 16'd16, 16'd1);
        wait_done(500);
        check("post_rst_frame", 64'(hs_cnt - h0), 64'd1);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
